// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the SubBytes engine.
//   byte_t / state_t : 8-bit byte and 128-bit state (byte 0 in the MSBs)
//   fsm_e            : engine FSM encoding {IDLE, BUSY, DONE}
//   AES_STATE_BYTES  : bytes per AES state
//   get_byte         : extract byte i from a state
//   shift_rows       : ShiftRows permutation, used when AES_SUBBYTES_SHIFTROWS_EN is defined
package aes_pkg;

  localparam int unsigned AES_STATE_BYTES = 16;

  typedef logic [7:0]                     byte_t;
  typedef logic [8*AES_STATE_BYTES-1:0]   state_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

  function automatic byte_t get_byte(state_t s, int unsigned i);
    return s[127-8*i -: 8];
  endfunction

  // out_byte[r+4c] = in_byte[r+4((c+r) mod 4)]
  function automatic state_t shift_rows(state_t s);
    state_t res;
    res = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        res[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_subbytes_engine_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) (x^254) followed
// by the FIPS-197 affine transform.
//   in_byte  : byte to substitute
//   out_byte : S-box output
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic byte_t xtime(byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul(byte_t a, byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Addition chain for x^254 (inverse, with 0 mapping to 0)
  function automatic byte_t ginv(byte_t x);
    byte_t x2, x3, x12, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  byte_t inv;

  always_comb begin
    inv      = ginv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_subbytes_engine.sv
// Sequential SubBytes stage: accepts a 128-bit state, substitutes LANES bytes
// per cycle over 16/LANES cycles, presents the result with valid/ready.
// Optional macro AES_SUBBYTES_SHIFTROWS_EN folds ShiftRows into the output.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake, in_state = state to substitute
//   out_valid/out_ready  : downstream handshake, out_state = substituted state
// Parameter LANES: S-box instances / bytes per cycle, one of 1,2,4,8,16.
module aes_subbytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int unsigned N  = AES_STATE_BYTES / LANES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  fsm_e          state;
  logic [CW-1:0] cnt;
  byte_t         work     [AES_STATE_BYTES];
  byte_t         sub_work [AES_STATE_BYTES];
  byte_t         lane_out [LANES];
  logic [3:0]    lane_idx [LANES];
  state_t        sub_state;
  state_t        next_out;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = 4'((int'(cnt) * int'(LANES)) + l);
    sbox u_sbox (
      .in_byte  (work[lane_idx[l]]),
      .out_byte (lane_out[l])
    );
  end

  // Work register with the current lane group substituted
  always_comb begin
    for (int unsigned i = 0; i < AES_STATE_BYTES; i++) sub_work[i] = work[i];
    for (int unsigned l = 0; l < LANES; l++) sub_work[lane_idx[l]] = lane_out[l];
  end

  always_comb begin
    sub_state = '0;
    for (int unsigned i = 0; i < AES_STATE_BYTES; i++) sub_state[127-8*i -: 8] = sub_work[i];
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    next_out = shift_rows(sub_state);
`else
    next_out = sub_state;
`endif
  end

  // out_state is captured on the final BUSY edge so it stays frozen through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_state <= '0;
      for (int unsigned i = 0; i < AES_STATE_BYTES; i++) work[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < AES_STATE_BYTES; i++) work[i] <= get_byte(in_state, i);
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          for (int unsigned i = 0; i < AES_STATE_BYTES; i++) work[i] <= sub_work[i];
          if (cnt == CW'(N - 1)) begin
            cnt       <= '0;
            out_state <= next_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_subbytes_engine.sv
// Directed bench for aes_subbytes_engine with a table-based S-box reference.
module tb_aes_subbytes_engine;

  localparam int unsigned LANES = 4;
  localparam int unsigned N     = 16 / LANES;

  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] KV_IN  = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_SUBBYTES_SHIFTROWS_EN
  localparam logic [127:0] KV_EXP = 128'h63fcac161bee28c3c4c193f54b8233ea;
`else
  localparam logic [127:0] KV_EXP = 128'h638293c31bfc33f5c4eeacea4bc12816;
`endif
  localparam logic [127:0] ALL63 = {16{8'h63}};
  localparam logic [127:0] ALL16 = {16{8'h16}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  aes_subbytes_engine #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] sbox_ref(logic [7:0] b);
    logic [127:0] row;
    row = SBOX_ROWS[b[7:4]];
    return row[127-8*b[3:0] -: 8];
  endfunction

  function automatic logic [127:0] expect_of(logic [127:0] s);
    logic [127:0] sb;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox_ref(s[127-8*i -: 8]);
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
`else
    res = sb;
`endif
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid with a cycle budget; returns the cycles waited
  task automatic wait_valid(output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (out_valid !== 1'b1 && waited < 60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int last_acc;
    logic [127:0] v;

    // Reset with in_valid asserted: nothing may be accepted
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    tick(); tick(); tick();
    chk("rst_in_ready",  {127'b0, in_ready},  128'd1);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_out_state", out_state, '0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_out_valid", {127'b0, out_valid}, 128'd0);

    // Known vector, latency N after accept
    in_valid = 1'b1; in_state = KV_IN;
    tick();
    in_valid = 1'b0;
    chk("kv_busy_in_ready", {127'b0, in_ready}, 128'd0);
    wait_valid(waited);
    chk("kv_latency", 128'(waited), 128'(N));
    chk("kv_out_state", out_state, KV_EXP);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("kv_hs_out_valid", {127'b0, out_valid}, 128'd0);
    chk("kv_hs_in_ready",  {127'b0, in_ready},  128'd1);

    // Backpressure: zero state, stalled 10 cycles, second input held valid meanwhile
    in_valid = 1'b1; in_state = '0;
    tick();
    in_state = '1;
    wait_valid(waited);
    chk("bp_latency", 128'(waited), 128'(N));
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_state", out_state, ALL63);
      chk("bp_hold_valid", {127'b0, out_valid}, 128'd1);
      chk("bp_hold_in_ready", {127'b0, in_ready}, 128'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_hs_in_ready", {127'b0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_accept", {127'b0, in_ready}, 128'd0);
    wait_valid(waited);
    chk("bp_second_state", out_state, ALL16);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during BUSY
    in_valid = 1'b1; in_state = KV_IN;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  {127'b0, in_ready},  128'd1);
    chk("midrst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("midrst_out_state", out_state, '0);
    tick();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_state = '1;
    tick();
    in_valid = 1'b0;
    wait_valid(waited);
    chk("midrst_latency", 128'(waited), 128'(N));
    chk("midrst_next_state", out_state, ALL16);
    out_ready = 1'b1;
    tick();

    // Back-to-back random stream with out_ready held high
    in_valid = 1'b1;
    last_acc = 0;
    for (int k = 0; k < 8; k++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      in_state = v;
      chk("b2b_in_ready", {127'b0, in_ready}, 128'd1);
      tick();
      if (k > 0) chk("b2b_period", 128'(cyc - last_acc), 128'(N + 2));
      last_acc = cyc;
      wait_valid(waited);
      chk("b2b_latency", 128'(waited), 128'(N));
      chk("b2b_state", out_state, expect_of(v));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
